// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, valid/ready byte hand-off.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote over the last three synchronised samples.
module uart_rx #(
    parameter int BAUD_LENGTH_IN_CYCLES = 125_000_000 / 115_200
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       UART_RX,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = BAUD_LENGTH_IN_CYCLES / 2;
    localparam int CW   = $clog2(BAUD_LENGTH_IN_CYCLES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_rx_s;
    logic            r_rx_prev;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_sample;
    logic            w_at_half;
    logic            w_at_baud;
    logic            w_cnt_clr;
    logic            w_enter_data;
    logic            w_shift_en;
    logic            w_stop_ok;
    logic            w_stop_bad;
    logic            w_xfer;

    // Synchroniser and edge history; idle-high line so everything resets to 1
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= UART_RX;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_rx_prev2;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_rx_prev2 <= 1'b1;
        end else begin
            r_rx_prev2 <= r_rx_prev;
        end
    end

    assign w_sample = (r_rx_s & r_rx_prev) | (r_rx_s & r_rx_prev2) | (r_rx_prev & r_rx_prev2);
`else
    assign w_sample = r_rx_s;
`endif

    assign w_at_half = (r_count == CW'(HALF - 1));
    assign w_at_baud = (r_count == CW'(BAUD_LENGTH_IN_CYCLES - 1));
    assign w_xfer    = data_valid & data_ready;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_clr    = 1'b0;
        w_enter_data = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_next    = START;
                    w_cnt_clr = 1'b1;
                end
            end
            START: begin
                if (w_at_half) begin
                    w_cnt_clr = 1'b1;
                    if (w_sample) begin
                        w_next = IDLE;
                    end else begin
                        w_next       = DATA;
                        w_enter_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_at_baud) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_at_baud) begin
                    w_cnt_clr  = 1'b1;
                    w_next     = IDLE;
                    w_stop_ok  = w_sample;
                    w_stop_bad = ~w_sample;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Timing and hand-off; a completed byte takes priority over clearing valid
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_count     <= '0;
            r_bit_idx   <= 3'd0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_count     <= w_cnt_clr ? '0 : r_count + CW'(1);
            frame_error <= w_stop_bad;
            overrun     <= 1'b0;
            if (w_enter_data) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_stop_ok) begin
                data_out   <= r_shift;
                data_valid <= 1'b1;
                overrun    <= data_valid & ~data_ready;
            end else if (w_xfer) begin
                data_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_shift_en) begin
            r_shift <= {w_sample, r_shift[7:1]};
        end
    end

endmodule
